flag_stack_register: RTL and testbench
======================================

# flag_stack_register

Parametrised status-flag register for the UT datapath, replacing the single-bit carry register. It holds WIDTH flags (C, Z, N, V by default) with independent per-bit load, set and clear. A DEPTH-entry LIFO lets the controller save flags on call/interrupt entry and restore them on return. Sticky error bits report stack overflow and underflow.

## Interface
- WIDTH, 4, number of flag bits (bit 0 = carry, 1 = zero, 2 = negative, 3 = overflow when WIDTH=4); legal range 1..16
- DEPTH, 4, save-stack entries; legal range 1..32
- RESET_VAL, {WIDTH{1'b0}}, value of flags_out after reset
- CW, $clog2(DEPTH+1), width of depth_count (derived; not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; gates every state change including error bits
- load_mask  in  WIDTH  per-bit load enable: flag[i] <= flags_in[i]
- flags_in  in  WIDTH  new flag values from ALU
- set_mask  in  WIDTH  per-bit force to 1
- clear_mask  in  WIDTH  per-bit force to 0
- push  in  1  save current flags onto stack
- pop  in  1  restore flags from top of stack
- err_clear  in  1  clear both sticky error bits
- flags_out  out  WIDTH  current flags (registered)
- depth_count  out  CW  number of stacked entries, 0..DEPTH
- stack_empty  out  1  depth_count == 0 (combinational from registered count)
- stack_full  out  1  depth_count == DEPTH
- overflow_err  out  1  sticky: push attempted while full
- underflow_err  out  1  sticky: pop attempted while empty

## Operation
- Reset (rst_n low, async): flags_out=RESET_VAL, depth_count=0, overflow_err=0, underflow_err=0; stack contents don't-care.
- ce=0: no register changes; all inputs ignored.
- Per-bit flag update (ce=1, no effective pop): load_mask[i] > clear_mask[i] > set_mask[i] > hold. This matches the old carry priority of load over clear.
- Push only (effective when not full): stack[depth_count] <= flags_out as registered *before* this edge; depth_count+1. Mask updates apply to flags_out in the same cycle.
- Pop only (effective when not empty): flags_out <= stack[depth_count-1]; depth_count-1. Pop overrides all masks for all bits.
- Push and pop in the same cycle: no stack operation and no error; depth_count unchanged. Masks apply normally.
- Push while full (pop=0): stack and count unchanged; overflow_err <= 1. Masks still apply.
- Pop while empty (push=0): count unchanged; underflow_err <= 1. Masks apply as if no pop.
- err_clear: both error bits <= 0, unless a new error occurs in the same cycle. A new error sets its bit and wins over err_clear.
- Overlapping masks on the same bit resolve strictly by the priority above; no error is raised.

## Timing
- All outputs are registered; a change takes effect on the rising edge where ce=1 and is visible the following cycle.
- Push→pop round trip: flags pushed at edge N come back on flags_out after a pop at edge M>N, visible in cycle M+1.
- Back-to-back push/pop every cycle is supported with no bubbles.
- Reset asserted mid-operation clears state immediately; the first usable edge is the first rising edge after rst_n deasserts.
- Width rule: the stack is DEPTH×WIDTH storage. depth_count never exceeds DEPTH and never wraps.

## Test plan
- Reset/priority: RESET_VAL=0; after reset, apply load_mask=4'b0011, flags_in=4'b0001, clear_mask=4'b0001, set_mask=4'b1000 → flags_out=4'b1001.
- ce gating: flags=4'b1010, ce=0 with load_mask=4'hF, flags_in=0, push=1 → flags_out stays 4'b1010 and depth_count stays 0.
- Push/pop with concurrent update: flags=4'b0110; push together with load_mask=4'hF, flags_in=4'b0001 → flags_out=4'b0001 and depth_count=1. Then pop with set_mask=4'hF → flags_out=4'b0110 and depth_count=0.
- Full/overflow: with DEPTH=4, push 5 times (flags 1,2,3,4,5) → depth_count=4, stack_full=1, overflow_err=1. Four pops then return 4,3,2,1.
- Empty/underflow: with the stack empty, pop with load_mask=4'h1, flags_in=4'h1 → flags bit0=1, depth_count=0, underflow_err=1. err_clear → 0. Pop+err_clear on an empty stack → underflow_err stays 1.
- Simultaneous push+pop and async reset: at depth 2, push+pop → depth stays 2, top entry unchanged. Then assert rst_n low mid-cycle → flags_out=RESET_VAL and depth_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/flag_stack_register.sv
// Status-flag register with per-bit load/clear/set and a LIFO save stack for
// call/interrupt flag preservation, plus sticky overflow/underflow error bits.
module flag_stack_register #(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    localparam int unsigned     CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] load_mask,
    input  logic [WIDTH-1:0] flags_in,
    input  logic [WIDTH-1:0] set_mask,
    input  logic [WIDTH-1:0] clear_mask,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clear,
    output logic [WIDTH-1:0] flags_out,
    output logic [CW-1:0]    depth_count,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] flags_q, flags_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] stack_q [DEPTH];

    logic             empty, full;
    logic             push_eff, pop_eff, ovf_evt, unf_evt;
    logic [AW-1:0]    wr_idx, rd_idx;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Push and pop together cancel: no stack movement and no error.
    assign push_eff = push & ~pop & ~full;
    assign pop_eff  = pop & ~push & ~empty;
    assign ovf_evt  = push & ~pop & full;
    assign unf_evt  = pop & ~push & empty;

    assign wr_idx = AW'(count_q);
    assign rd_idx = AW'(count_q - CW'(1));

    always_comb begin
        flags_d = flags_q;
        if (pop_eff) begin
            flags_d = stack_q[rd_idx];
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (load_mask[i])       flags_d[i] = flags_in[i];
                else if (clear_mask[i]) flags_d[i] = 1'b0;
                else if (set_mask[i])   flags_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push_eff)     count_d = count_q + CW'(1);
        else if (pop_eff) count_d = count_q - CW'(1);
    end

    // A new error in the same cycle wins over err_clear.
    assign ovf_d = ovf_evt | (ovf_q & ~err_clear);
    assign unf_d = unf_evt | (unf_q & ~err_clear);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= RESET_VAL;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (ce) begin
            flags_q <= flags_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // NOTE: stack storage has no reset; entries above depth_count are never read.
    always_ff @(posedge clk) begin
        if (ce && push_eff) stack_q[wr_idx] <= flags_q;
    end

    assign flags_out     = flags_q;
    assign depth_count   = count_q;
    assign stack_empty   = empty;
    assign stack_full    = full;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_flag_stack_register.sv
// Scoreboard bench for flag_stack_register: directed test-plan vectors then
// random traffic, compared against a queue-based behavioural model.
module tb_flag_stack_register;

    localparam int W = 4;
    localparam int D = 4;

    typedef struct packed {
        logic [W-1:0] flags;
        logic [2:0]   depth;
        logic         empty;
        logic         full;
        logic         ovf;
        logic         unf;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ce = 1'b0;
    logic [W-1:0] load_mask = '0, flags_in = '0, set_mask = '0, clear_mask = '0;
    logic         push = 1'b0, pop = 1'b0, err_clear = 1'b0;
    logic [W-1:0] flags_out;
    logic [2:0]   depth_count;
    logic         stack_empty, stack_full, overflow_err, underflow_err;

    flag_stack_register #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .load_mask(load_mask), .flags_in(flags_in),
        .set_mask(set_mask), .clear_mask(clear_mask),
        .push(push), .pop(pop), .err_clear(err_clear),
        .flags_out(flags_out), .depth_count(depth_count),
        .stack_empty(stack_empty), .stack_full(stack_full),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [W-1:0] m_flags;
    logic [W-1:0] m_stack[$];
    logic         m_ovf, m_unf;

    obs_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic obs_t model_obs();
        obs_t o;
        o.flags = m_flags;
        o.depth = 3'(m_stack.size());
        o.empty = (m_stack.size() == 0);
        o.full  = (m_stack.size() == D);
        o.ovf   = m_ovf;
        o.unf   = m_unf;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.flags = flags_out;
        o.depth = depth_count;
        o.empty = stack_empty;
        o.full  = stack_full;
        o.ovf   = overflow_err;
        o.unf   = underflow_err;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got flags=%b depth=%0d empty=%b full=%b ovf=%b unf=%b, expected flags=%b depth=%0d empty=%b full=%b ovf=%b unf=%b",
                     name, $time, act.flags, act.depth, act.empty, act.full, act.ovf, act.unf,
                     exp.flags, exp.depth, exp.empty, exp.full, exp.ovf, exp.unf);
        end
    endtask

    task automatic model_reset();
        m_flags = '0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using the applied inputs.
    task automatic model_step();
        logic [W-1:0] old;
        int           sz;
        if (!ce) return;
        old = m_flags;
        sz  = m_stack.size();
        if (pop && !push && sz > 0) begin
            m_flags = m_stack.pop_back();
        end else begin
            m_flags = (load_mask & flags_in) | (~load_mask & ~clear_mask & (set_mask | old));
            if (push && !pop && sz < D) m_stack.push_back(old);
        end
        m_ovf = (push && !pop && sz == D) ? 1'b1 : (err_clear ? 1'b0 : m_ovf);
        m_unf = (pop && !push && sz == 0) ? 1'b1 : (err_clear ? 1'b0 : m_unf);
    endtask

    task automatic drive(input logic c, input logic [W-1:0] ld, input logic [W-1:0] fi,
                         input logic [W-1:0] cl, input logic [W-1:0] st,
                         input logic pu, input logic po, input logic ec);
        @(negedge clk);
        ce = c; load_mask = ld; flags_in = fi; clear_mask = cl; set_mask = st;
        push = pu; pop = po; err_clear = ec;
        @(posedge clk);
        model_step();
        exp_q.push_back(model_obs());
    endtask

    task automatic load_flags(input logic [W-1:0] v);
        drive(1'b1, 4'hF, v, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: registered outputs are sampled at the falling edge after each vector.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) check("cycle", dut_obs(), exp_q.pop_front());
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2 check("reset_state", dut_obs(), model_obs());
        @(negedge clk) rst_n = 1'b1;

        // Priority: load > clear > set
        drive(1'b1, 4'b0011, 4'b0001, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b0);

        // ce gating
        load_flags(4'b1010);
        drive(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);

        // Push with concurrent load, then pop overriding set_mask
        load_flags(4'b0110);
        drive(1'b1, 4'hF, 4'b0001, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0);

        // Fill past DEPTH, then drain in LIFO order
        for (int k = 1; k <= 5; k++) begin
            load_flags(4'(k));
            drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        end
        repeat (4) drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Underflow with mask update, clear, then error wins over err_clear
        drive(1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);

        // Simultaneous push+pop at depth 2, then pop to expose the top entry
        load_flags(4'hA);
        drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        load_flags(4'h5);
        drive(1'b1, 4'hF, 4'h3, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'hF, 4'hC, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset asserted mid-cycle
        @(negedge clk);
        ce = 1'b0;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check("async_reset", dut_obs(), model_obs());
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(9, 0) != 0),
                  4'($urandom & $urandom), 4'($urandom),
                  4'($urandom & $urandom), 4'($urandom & $urandom),
                  ($urandom_range(2, 0) == 0), ($urandom_range(2, 0) == 0),
                  ($urandom_range(7, 0) == 0));
        end

        @(negedge clk);
        ce = 1'b0;
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
